move_scheduler: RTL

- Sequences the direction validator across all 8 board directions for one candidate move. It runs after the player selects a cell and before the flip engine.
- For each direction it decides whether a capture run can geometrically fit. If it fits, it loads the validator with start address, step and player, enables it, and records the pass/fail result.
- Produces an 8-bit capture mask and an overall legal flag. It also guards against a hung validator with a per-direction timeout.

---
 rtl/othello_pkg.sv | 30 +++
 rtl/dir_fit_check.sv | 24 ++
 rtl/move_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/othello_pkg.sv
// Shared types and constants for the move legality sequencer.
// Directions are indexed N, NE, E, SE, S, SW, W, NW.
package othello_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        RUN,
        NEXT,
        DONE
    } state_e;

    localparam int BOARD_DIM = 8;

    localparam logic [1:0] PLAYER_DATA [2] = '{2'b01, 2'b10};

    localparam logic signed [4:0] DIR_DY [8] = '{
        -5'sd1, -5'sd1, 5'sd0, 5'sd1, 5'sd1, 5'sd1, 5'sd0, -5'sd1
    };

    localparam logic signed [4:0] DIR_DX [8] = '{
        5'sd0, 5'sd1, 5'sd1, 5'sd1, 5'sd0, -5'sd1, -5'sd1, -5'sd1
    };

    localparam logic signed [4:0] DIR_STEP [8] = '{
        -5'sd8, -5'sd7, 5'sd1, 5'sd9, 5'sd8, 5'sd7, -5'sd1, -5'sd9
    };

endpackage

// File: rtl/dir_fit_check.sv
// Decides whether a capture run (opponent + closing cell) fits on the
// board in direction d, and supplies the address step for it.
module dir_fit_check
    import othello_pkg::*;
(
    input  logic [2:0] row_i,
    input  logic [2:0] col_i,
    input  logic [2:0] d_i,
    output logic       fit_o,
    output logic [4:0] step_o
);

    logic signed [4:0] r_end;
    logic signed [4:0] c_end;

    // Two cells out; on board exactly when the 5-bit result is 0..7.
    always_comb begin
        r_end  = $signed({2'b00, row_i}) + (DIR_DY[d_i] <<< 1);
        c_end  = $signed({2'b00, col_i}) + (DIR_DX[d_i] <<< 1);
        fit_o  = (r_end[4:3] == 2'b00) && (c_end[4:3] == 2'b00);
        step_o = DIR_STEP[d_i];
    end

endmodule

// File: rtl/move_scheduler.sv
// Walks the direction validator over all 8 directions of one candidate
// move and collects a capture mask, legal flag and timeout flag.
module move_scheduler
    import othello_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] addr_in,
    input  logic       player,
    input  logic       cell_empty,
    input  logic       v_dir_status,
    input  logic       v_done,
    output logic       v_ld,
    output logic       v_enable,
    output logic [6:0] v_addr,
    output logic [4:0] v_step,
    output logic       v_player,
    output logic       busy_o,
    output logic       done_o,
    output logic       legal_o,
    output logic [7:0] dir_mask_o,
    output logic       timeout_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic [2:0]    d_q, d_d;
    logic [5:0]    addr_q, addr_d;
    logic          player_q, player_d;
    logic [7:0]    mask_q, mask_d;
    logic          legal_q, legal_d;
    logic          to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          fit;
    logic [4:0]    step;

    dir_fit_check u_fit (
        .row_i  (addr_q[5:3]),
        .col_i  (addr_q[2:0]),
        .d_i    (d_q),
        .fit_o  (fit),
        .step_o (step)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            d_q      <= '0;
            addr_q   <= '0;
            player_q <= 1'b0;
            mask_q   <= '0;
            legal_q  <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            addr_q   <= addr_d;
            player_q <= player_d;
            mask_q   <= mask_d;
            legal_q  <= legal_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        addr_d   = addr_q;
        player_d = player_q;
        mask_d   = mask_q;
        legal_d  = legal_q;
        to_d     = to_q;
        cnt_d    = cnt_q;
        // Abort freezes all results; only the state returns to IDLE.
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d   = addr_in;
                        player_d = player;
                        mask_d   = '0;
                        legal_d  = 1'b0;
                        to_d     = 1'b0;
                        d_d      = '0;
                        state_d  = cell_empty ? CHECK : DONE;
                    end
                end
                CHECK: begin
                    if (fit) begin
                        state_d = LOAD;
                    end else begin
                        mask_d[d_q] = 1'b0;
                        state_d     = NEXT;
                    end
                end
                LOAD: begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    cnt_d = cnt_q + CW'(1);
                    if (v_done) begin
                        mask_d[d_q] = v_dir_status;
                        state_d     = NEXT;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        mask_d[d_q] = 1'b0;
                        to_d        = 1'b1;
                        state_d     = NEXT;
                    end
                end
                NEXT: begin
                    if (d_q == 3'd7) begin
                        legal_d = |mask_q;
                        state_d = DONE;
                    end else begin
                        d_d     = d_q + 3'd1;
                        state_d = CHECK;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign v_ld       = (state_q == LOAD) && !abort;
    assign v_enable   = (state_q == RUN) && !abort;
    assign v_addr     = {1'b0, addr_q};
    assign v_step     = (state_q == LOAD || state_q == RUN) ? step : 5'd0;
    assign v_player   = player_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE) && !abort;
    assign legal_o    = legal_q;
    assign dir_mask_o = mask_q;
    assign timeout_o  = to_q;

endmodule
